// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM between NREQ requesters.
// Optional macro ROM_ARB_RANGE_CHK_EN: out-of-range addresses skip the ROM and return rerr.
module rom_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int AW    = 5,
  parameter int DW    = 4,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]  gnt,
  output logic             rvalid,
  output logic [2:0]       rid,
  output logic [DW-1:0]    rdata,
  output logic             rerr,
  output logic             rom_en,
  output logic [AW-1:0]    rom_addr,
  input  logic [DW-1:0]    rom_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t            state, state_next;
  logic [2:0]        last, last_next;
  logic [2:0]        cur, cur_next;
  logic [NREQ-1:0]   gnt_next;
  logic              rom_en_next;
  logic [AW-1:0]     rom_addr_next;
  logic              rvalid_next;
  logic [2:0]        rid_next;
  logic [DW-1:0]     rdata_next;

  logic [NREQ-1:0]   hi_mask, masked, pick_src, win_oh;
  logic [AW-1:0]     win_addr;
  logic [2:0]        win_id;

  // Requesters above the last winner get first pick; otherwise wrap to the lowest index.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign hi_mask[gi] = (3'(gi) > last);
    end
  endgenerate

  assign masked   = req & hi_mask;
  assign pick_src = (|masked) ? masked : req;
  assign win_oh   = pick_src & (~pick_src + 1'b1);

  always_comb begin
    win_addr = '0;
    win_id   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        win_addr = req_addr[i*AW +: AW];
        win_id   = 3'(i);
      end
    end
  end

`ifdef ROM_ARB_RANGE_CHK_EN
  logic oor, oor_next;
  logic rerr_next;
  logic in_range;
  assign in_range = ({1'b0, win_addr} < (AW+1)'(DEPTH));
`endif

  always_comb begin
    state_next    = state;
    last_next     = last;
    cur_next      = cur;
    gnt_next      = '0;
    rom_en_next   = 1'b0;
    rom_addr_next = rom_addr;
    rvalid_next   = 1'b0;
    rid_next      = rid;
    rdata_next    = rdata;
`ifdef ROM_ARB_RANGE_CHK_EN
    oor_next      = oor;
    rerr_next     = rerr;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_next      = win_oh;
          rom_en_next   = 1'b1;
          rom_addr_next = win_addr;
          cur_next      = win_id;
          last_next     = win_id;
          state_next    = ISSUE;
`ifdef ROM_ARB_RANGE_CHK_EN
          oor_next = !in_range;
          if (!in_range) rom_en_next = 1'b0;
`endif
        end
      end
      ISSUE: state_next = CAPTURE;
      CAPTURE: begin
        rvalid_next = 1'b1;
        rid_next    = cur;
        rdata_next  = rom_data;
        state_next  = IDLE;
`ifdef ROM_ARB_RANGE_CHK_EN
        if (oor) rdata_next = '0;
        rerr_next = oor;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 3'(NREQ-1);
      cur      <= '0;
      gnt      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      rvalid   <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
    end else begin
      state    <= state_next;
      last     <= last_next;
      cur      <= cur_next;
      gnt      <= gnt_next;
      rom_en   <= rom_en_next;
      rom_addr <= rom_addr_next;
      rvalid   <= rvalid_next;
      rid      <= rid_next;
      rdata    <= rdata_next;
    end
  end

`ifdef ROM_ARB_RANGE_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oor  <= 1'b0;
      rerr <= 1'b0;
    end else begin
      oor  <= oor_next;
      rerr <= rerr_next;
    end
  end
`else
  assign rerr = 1'b0;
`endif

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Bench for rom_rr_arbiter: behavioural ROM, scoreboard of expected reads, per-scenario tasks.
module tb_rom_rr_arbiter;
  localparam int NREQ = 4;
  localparam int AW = 5;
  localparam int DW = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   gnt;
  logic              rvalid;
  logic [2:0]        rid;
  logic [DW-1:0]     rdata;
  logic              rerr;
  logic              rom_en;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data = '0;

  typedef struct { logic [2:0] id; logic [DW-1:0] data; logic err; } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int rom_en_cycles = 0;

  always #5 clk = ~clk;

  rom_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rvalid(rvalid), .rid(rid), .rdata(rdata), .rerr(rerr),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    case (a)
      5'd0: return 4'h6;  5'd1: return 4'hA;  5'd2: return 4'hE;  5'd3: return 4'h6;
      5'd4: return 4'hF;  5'd5: return 4'h3;  5'd6: return 4'h9;  5'd7: return 4'h1;
      5'd8: return 4'hC;  5'd9: return 4'h5;  5'd10: return 4'h7; 5'd11: return 4'h2;
      5'd12: return 4'hB; 5'd13: return 4'hD; 5'd14: return 4'h8; 5'd15: return 4'h4;
      default: return 4'h0;
    endcase
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= rom_word(rom_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int id, input logic [AW-1:0] a);
    req_addr[id*AW +: AW] = a;
  endtask

  task automatic push_exp(input int id, input logic [AW-1:0] a);
    exp_t e;
    e.id = 3'(id);
`ifdef ROM_ARB_RANGE_CHK_EN
    e.err  = (a >= AW'(DEPTH));
    e.data = e.err ? '0 : rom_word(a);
`else
    e.err  = 1'b0;
    e.data = rom_word(a);
`endif
    sb.push_back(e);
  endtask

  task automatic wait_gnt(output logic ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      waited++;
      if (gnt !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic reset_dut;
    req = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Read-data scoreboard and hold check, sampled on the falling edge.
  initial begin
    exp_t e;
    logic [DW-1:0] hold_rdata;
    logic [2:0] hold_rid;
    hold_rdata = '0;
    hold_rid = '0;
    forever begin
      @(negedge clk);
      if (rom_en) rom_en_cycles++;
      if (rst) begin
        hold_rdata = '0;
        hold_rid = '0;
      end else if (rvalid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rvalid: got rid=%0d rdata=%h, required no rvalid", rid, rdata);
        end else begin
          e = sb.pop_front();
          if ({rid, rdata, rerr} !== {e.id, e.data, e.err}) begin
            miscompares++;
            $display("FAIL read_data: got rid=%0d rdata=%h rerr=%b, required rid=%0d rdata=%h rerr=%b",
                     rid, rdata, rerr, e.id, e.data, e.err);
          end
        end
        hold_rdata = rdata;
        hold_rid = rid;
      end else begin
        vectors++;
        if (rdata !== hold_rdata || rid !== hold_rid) begin
          miscompares++;
          $display("FAIL hold: got rid=%0d rdata=%h, required rid=%0d rdata=%h", rid, rdata, hold_rid, hold_rdata);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    req = '0;
    req_addr = '0;
    tick();
    vectors++;
    if ({gnt, rvalid, rid, rdata, rerr, rom_en, rom_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got gnt=%b rvalid=%b rid=%0d rdata=%h rerr=%b rom_en=%b rom_addr=%h, required all 0",
               gnt, rvalid, rid, rdata, rerr, rom_en, rom_addr);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic ok; int w;
    reset_dut();
    set_addr(0, 5'h04);
    req = 4'b0001;
    push_exp(0, 5'h04);
    wait_gnt(ok, w);
    vectors++;
    if (!ok || w != 1 || gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_gnt: got gnt=%b after %0d cycles, required 0001 after 1", gnt, w);
    end
    vectors++;
    if (rom_en !== 1'b1 || rom_addr !== 5'h04) begin
      miscompares++;
      $display("FAIL single_rom_issue: got rom_en=%b rom_addr=%h, required 1 04", rom_en, rom_addr);
    end
    req = '0;
    tick();
    vectors++;
    if (gnt !== '0 || rom_en !== 1'b0 || rom_addr !== 5'h04) begin
      miscompares++;
      $display("FAIL single_pulse_width: got gnt=%b rom_en=%b rom_addr=%h, required 0000 0 04", gnt, rom_en, rom_addr);
    end
    tick();
    vectors++;
    if (rvalid !== 1'b1 || rdata !== 4'hF || rid !== 3'd0) begin
      miscompares++;
      $display("FAIL single_latency: got rvalid=%b rdata=%h rid=%0d, required 1 F 0", rvalid, rdata, rid);
    end
    tick();
    tick();
  endtask

  task automatic test_round_robin;
    logic ok; int w;
    int order[5] = '{0, 1, 2, 3, 0};
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_addr(i, 5'(i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_exp(order[k], 5'(order[k]));
      wait_gnt(ok, w);
      vectors++;
      if (!ok || gnt !== 4'(1 << order[k]) || w != (k == 0 ? 1 : 3)) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got gnt=%b after %0d cycles, required %b after %0d",
                 k, gnt, w, 4'(1 << order[k]), (k == 0 ? 1 : 3));
      end
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_wrap;
    logic ok; int w;
    reset_dut();
    set_addr(2, 5'h02);
    set_addr(0, 5'h05);
    req = 4'b0100;
    push_exp(2, 5'h02);
    wait_gnt(ok, w);
    vectors++;
    if (!ok || gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL wrap_first: got gnt=%b, required 0100", gnt);
    end
    req = 4'b0101;
    push_exp(0, 5'h05);
    wait_gnt(ok, w);
    vectors++;
    if (!ok || gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL wrap_to_zero: got gnt=%b, required 0001", gnt);
    end
    req = 4'b0100;
    push_exp(2, 5'h02);
    wait_gnt(ok, w);
    vectors++;
    if (!ok || gnt !== 4'b0100) begin
      miscompares++;
      $display("FAIL wrap_back: got gnt=%b, required 0100", gnt);
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_abort;
    logic ok; int w;
    reset_dut();
    set_addr(1, 5'h01);
    req = 4'b0010;
    wait_gnt(ok, w);
    vectors++;
    if (!ok || gnt !== 4'b0010) begin
      miscompares++;
      $display("FAIL abort_setup: got gnt=%b, required 0010", gnt);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({gnt, rvalid, rid, rdata, rerr, rom_en, rom_addr} !== '0) begin
      miscompares++;
      $display("FAIL abort_async: got gnt=%b rvalid=%b rom_en=%b rom_addr=%h, required all 0", gnt, rvalid, rom_en, rom_addr);
    end
    req = '0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_no_rvalid: got rvalid=%b at cycle %0d, required 0", rvalid, c);
      end
    end
    set_addr(0, 5'h00);
    req = 4'b0011;
    push_exp(0, 5'h00);
    wait_gnt(ok, w);
    vectors++;
    if (!ok || gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL abort_pointer: got gnt=%b, required 0001", gnt);
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_out_of_range;
    logic ok; int w;
    reset_dut();
    set_addr(0, 5'h10);
    req = 4'b0001;
    push_exp(0, 5'h10);
    wait_gnt(ok, w);
    vectors++;
`ifdef ROM_ARB_RANGE_CHK_EN
    if (!ok || gnt !== 4'b0001 || rom_en !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_issue: got gnt=%b rom_en=%b, required 0001 0", gnt, rom_en);
    end
`else
    if (!ok || gnt !== 4'b0001 || rom_en !== 1'b1 || rom_addr !== 5'h10) begin
      miscompares++;
      $display("FAIL oor_issue: got gnt=%b rom_en=%b rom_addr=%h, required 0001 1 10", gnt, rom_en, rom_addr);
    end
`endif
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_pulse_ignored;
    logic ok; int w; int cnt0; logic seen;
    reset_dut();
    set_addr(0, 5'h03);
    req = 4'b0001;
    push_exp(0, 5'h03);
    wait_gnt(ok, w);
    vectors++;
    if (!ok || gnt !== 4'b0001) begin
      miscompares++;
      $display("FAIL pulse_setup: got gnt=%b, required 0001", gnt);
    end
    req = '0;
    tick();
    cnt0 = rom_en_cycles;
    set_addr(1, 5'h04);
    req = 4'b0010;
    tick();
    req = '0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (gnt !== '0) seen = 1'b1;
    end
    vectors++;
    if (seen || rom_en_cycles != cnt0) begin
      miscompares++;
      $display("FAIL pulse_ignored: got grant_seen=%b rom_accesses=%0d, required 0 0", seen, rom_en_cycles - cnt0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_reset_abort();
    test_out_of_range();
    test_pulse_ignored();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_rvalid: got %0d outstanding reads, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
